// File: rtl/depremuat1_4_stream_if.sv
// Handshake bus for depremuat1_4_stream.
// Serial coefficient input with valid/ready, and a parallel natural-order row output with valid/ready.
// master: the surrounding datapath. slave: the permutation buffer.
interface depremuat1_4_stream_if;
    logic               i_valid;
    logic signed [18:0] i_data;
    logic               i_ready;
    logic               o_valid;
    logic               o_ready;
    logic signed [18:0] o_0;
    logic signed [18:0] o_1;
    logic signed [18:0] o_2;
    logic signed [18:0] o_3;

    modport master (
        output i_valid, i_data, o_ready,
        input  i_ready, o_valid, o_0, o_1, o_2, o_3
    );

    modport slave (
        input  i_valid, i_data, o_ready,
        output i_ready, o_valid, o_0, o_1, o_2, o_3
    );
endinterface

// File: rtl/depremuat1_4_stream.sv
// depremuat1_4_stream: 4-point inverse-permutation ping-pong buffer.
// Coefficients arrive serially in butterfly order {0,2,1,3}. Each one is written
// into its natural slot. Complete rows leave as four parallel words.
// Optional feature: define DEPREMUAT_BYPASS_EN to add i_bypass. A row started with
// i_bypass high uses the identity mapping, so the block acts as a plain
// serial-to-parallel buffer.
module depremuat1_4_stream (
    input  logic clk,
    input  logic rst_n,
`ifdef DEPREMUAT_BYPASS_EN
    input  logic i_bypass,
`endif
    depremuat1_4_stream_if.slave bus
);
    // Per-bank state: a bank is either filling/idle or holding a complete row.
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [1:0][3:0][18:0] bank;
    logic [1:0][0:0]       bst;
    logic                  wr_bank;
    logic                  rd_bank;
    logic [1:0]            wr_cnt;
    logic                  in_fire;
    logic                  out_fire;
    logic                  row_done;
    logic                  byp_row;
    logic [1:0]            slot;

    // Handshakes are derived from registered bank state only.
    // There is no combinational path from o_ready to i_ready, nor from i_valid to o_valid.
    assign bus.i_ready = (bst[wr_bank] == ST_EMPTY);
    assign bus.o_valid = (bst[rd_bank] == ST_FULL);
    assign in_fire     = bus.i_valid && bus.i_ready;
    assign out_fire    = bus.o_valid && bus.o_ready;
    assign row_done    = in_fire && (wr_cnt == 2'd3);

`ifdef DEPREMUAT_BYPASS_EN
    logic byp_q;

    // The bypass choice is taken from the first coefficient of a row and held for the rest of the row.
    assign byp_row = (wr_cnt == 2'd0) ? i_bypass : byp_q;

    // Latch the bypass choice when a row starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            byp_q <= 1'b0;
        else if (in_fire && (wr_cnt == 2'd0))
            byp_q <= i_bypass;
    end
`else
    assign byp_row = 1'b0;
`endif

    // The butterfly order {0,2,1,3} is self-inverse: the slot index is wr_cnt with its two bits swapped.
    assign slot = byp_row ? wr_cnt : {wr_cnt[0], wr_cnt[1]};

    // Write-side pointer and row counter. While both banks are full, no write can fire, so wr_cnt holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= 2'd0;
            wr_bank <= 1'b0;
        end else if (in_fire) begin
            wr_cnt <= wr_cnt + 2'd1;
            if (wr_cnt == 2'd3)
                wr_bank <= ~wr_bank;
        end
    end

    // Read-side pointer advances on every accepted row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_bank <= 1'b0;
        else if (out_fire)
            rd_bank <= ~rd_bank;
    end

    // Bank storage and per-bank EMPTY/FULL state.
    // The fill and the pop in the same cycle always target different banks,
    // because a write needs an empty bank and a pop needs a full one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
            for (int b = 0; b < 2; b++)
                bst[b] <= ST_EMPTY;
        end else begin
            if (in_fire)
                bank[wr_bank][slot] <= bus.i_data;
            for (int b = 0; b < 2; b++) begin
                if (row_done && (wr_bank == 1'(b)))
                    bst[b] <= ST_FULL;
                else if (out_fire && (rd_bank == 1'(b)))
                    bst[b] <= ST_EMPTY;
            end
        end
    end

    // Present the head row, forced to zero when no row is valid.
    always_comb begin
        bus.o_0 = '0;
        bus.o_1 = '0;
        bus.o_2 = '0;
        bus.o_3 = '0;
        if (bus.o_valid) begin
            bus.o_0 = bank[rd_bank][0];
            bus.o_1 = bank[rd_bank][1];
            bus.o_2 = bank[rd_bank][2];
            bus.o_3 = bank[rd_bank][3];
        end
    end
endmodule

// File: tb/tb_depremuat1_4_stream.sv
// Scoreboard bench for depremuat1_4_stream.
// Stimulus pushes hand-computed natural-order rows into exp_q.
// The monitor pops a row and compares it on every output transfer.
module tb_depremuat1_4_stream;
    typedef logic signed [18:0] w_t;
    typedef struct packed { w_t d0; w_t d1; w_t d2; w_t d3; } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef DEPREMUAT_BYPASS_EN
    logic i_bypass = 1'b0;
`endif

    depremuat1_4_stream_if bus ();

    depremuat1_4_stream dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef DEPREMUAT_BYPASS_EN
        .i_bypass (i_bypass),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    row_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   stalls = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic row_t mk(input int a, input int b, input int c, input int d);
        row_t r;
        r.d0 = w_t'(a); r.d1 = w_t'(b); r.d2 = w_t'(c); r.d3 = w_t'(d);
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input int d);
        int t;
        t = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = w_t'(d);
        @(negedge clk);
        while (!bus.i_ready && t < 200) begin
            stalls++;
            t++;
            @(negedge clk);
        end
        if (!bus.i_ready) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        bus.o_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.o_valid) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_o_valid", int'(bus.o_valid), 0);
    endtask

    // Monitor: compare each transferred row against the scoreboard head. An idle output must read zero.
    initial begin
        row_t r;
        forever begin
            @(negedge clk);
            if (rst_n && bus.o_valid && bus.o_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_row", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("row_o0", int'(bus.o_0), int'(r.d0));
                    chk("row_o1", int'(bus.o_1), int'(r.d1));
                    chk("row_o2", int'(bus.o_2), int'(r.d2));
                    chk("row_o3", int'(bus.o_3), int'(r.d3));
                end
            end else if (!bus.o_valid) begin
                chk("idle_outputs_zero", int'(bus.o_0 | bus.o_1 | bus.o_2 | bus.o_3), 0);
            end
        end
    end

    // Directed stimulus.
    initial begin
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.o_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_i_ready", int'(bus.i_ready), 1);
        chk("rst_o_valid", int'(bus.o_valid), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First row with latency check
        bus.o_ready = 1'b1;
        exp_q.push_back(mk(10, 30, 20, 40));
        send(10); send(20); send(30); send(40);
        chk("lat_o_valid_after_4th", int'(bus.o_valid), 1);
        @(posedge clk);
        #1;
        chk("lat_o_valid_next", int'(bus.o_valid), 0);

        // Continuous stream, no stalls expected
        stalls = 0;
        exp_q.push_back(mk(1, 3, 2, 4));
        exp_q.push_back(mk(5, 7, 6, 8));
        for (int i = 1; i <= 8; i++) send(i);
        chk("stream_no_stall", stalls, 0);
        drain();

        // Backpressure: two rows fill both banks, the ninth coefficient stalls
        bus.o_ready = 1'b0;
        exp_q.push_back(mk(101, 103, 102, 104));
        exp_q.push_back(mk(105, 107, 106, 108));
        exp_q.push_back(mk(109, 111, 110, 112));
        for (int i = 101; i <= 108; i++) send(i);
        chk("bp_i_ready_low", int'(bus.i_ready), 0);
        chk("bp_o_valid", int'(bus.o_valid), 1);
        chk("bp_head_o0", int'(bus.o_0), 101);
        fork
            begin
                for (int i = 109; i <= 112; i++) send(i);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("bp_still_stalled", int'(bus.i_ready), 0);
                chk("bp_o1_stable", int'(bus.o_1), 103);
                bus.o_ready = 1'b1;
                @(posedge clk);
                #1;
                bus.o_ready = 1'b0;
                chk("bp_i_ready_after_pop", int'(bus.i_ready), 1);
                chk("bp_next_head_o0", int'(bus.o_0), 105);
            end
        join
        drain();

        // Negative extremes pass bit-exact
        exp_q.push_back(mk(-262144, -1, 262143, 0));
        send(-262144); send(262143); send(-1); send(0);
        drain();

        // Reset mid-row discards the partial row
        send(91); send(92);
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", int'(bus.o_valid), 0);
        chk("midrst_i_ready", int'(bus.i_ready), 1);
        chk("midrst_o0", int'(bus.o_0), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(mk(5, 7, 6, 8));
        send(5); send(6); send(7); send(8);
        drain();

`ifdef DEPREMUAT_BYPASS_EN
        // Bypass latched at row start; mid-row toggles ignored
        exp_q.push_back(mk(1, 2, 3, 4));
        exp_q.push_back(mk(5, 7, 6, 8));
        i_bypass = 1'b1;
        send(1);
        i_bypass = 1'b0;
        send(2);
        i_bypass = 1'b1;
        send(3);
        i_bypass = 1'b0;
        send(4);
        send(5); send(6); send(7); send(8);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
